// File: rtl/dbf_fine_apod_ch.sv
// Per-channel DBF fine-delay stage: 2-tap linear interpolation with a LUT-driven
// fraction indexed by sample count, followed by apodization weighting.
module dbf_fine_apod_ch #(
    parameter int INPUT_WD = 14,
    parameter int FRAC_WD  = 4,
    parameter int ADDR_WD  = 12,
    parameter int APO_WD   = 16,
    parameter int OUT_WD   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_en,
    input  logic                start,
    input  logic [INPUT_WD-1:0] fine_din,
    input  logic                fine_din_valid,
    input  logic                lut_we,
    input  logic [ADDR_WD-1:0]  lut_addr,
    input  logic [FRAC_WD-1:0]  lut_wdata,
    input  logic [APO_WD-1:0]   apo_din,
    output logic [OUT_WD-1:0]   dbf_dout,
    output logic                dbf_dout_valid
);

    localparam int IW = INPUT_WD + FRAC_WD + 1;
    localparam int PW = IW + APO_WD;
    localparam int WW = FRAC_WD + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic                       acc;
    logic [ADDR_WD-1:0]         cnt_q, cnt_d;
    logic signed [INPUT_WD-1:0] prev_q, prev_d;
    logic signed [INPUT_WD-1:0] xn1;

    logic [FRAC_WD-1:0]         lut_mem [2**ADDR_WD];
    logic [FRAC_WD-1:0]         f1_q;

    logic                       v1_q, v1_d;
    logic                       v2_q, v2_d;
    logic                       v3_q, v3_d;
    logic signed [INPUT_WD-1:0] x1_q, x1_d;
    logic signed [INPUT_WD-1:0] xp1_q, xp1_d;
    logic signed [APO_WD-1:0]   apo1_q, apo1_d;
    logic signed [APO_WD-1:0]   apo2_q, apo2_d;
    logic signed [IW-1:0]       interp_q, interp_d;
    logic signed [PW-1:0]       prod_q, prod_d;
    logic [WW-1:0]              w_p, w_n;
    logic [OUT_WD-1:0]          dout_q, dout_d;
    logic                       dvld_q, dvld_d;

    assign acc = start & ~tx_en & fine_din_valid;

    always_comb begin : fsm_next
        state_d = state_q;
        if (!start) begin
            state_d = ST_IDLE;
        end else if (acc) begin
            state_d = ST_RUN;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_FIRST;
        end
    end

    always_comb begin : datapath
        cnt_d  = cnt_q;
        prev_d = prev_q;
        x1_d   = x1_q;
        xp1_d  = xp1_q;
        apo1_d = apo1_q;
        // Only a line that has already accepted a sample has a valid previous tap.
        xn1    = (state_q == ST_RUN) ? prev_q : '0;

        if (!start) begin
            cnt_d  = '0;
            prev_d = '0;
        end else if (acc) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            prev_d = signed'(fine_din);
            x1_d   = signed'(fine_din);
            xp1_d  = xn1;
            apo1_d = signed'(apo_din);
        end
        v1_d = acc;

        w_p      = {1'b0, f1_q};
        w_n      = WW'(2**FRAC_WD) - w_p;
        interp_d = IW'(x1_q) * signed'(IW'(w_n)) + IW'(xp1_q) * signed'(IW'(w_p));
        apo2_d   = apo1_q;
        v2_d     = start & v1_q;

        prod_d = PW'(interp_q) * PW'(apo2_q);
        v3_d   = start & v2_q;

        dvld_d = start & v3_q;
        dout_d = dout_q;
        if (!start) begin
            dout_d = '0;
        end else if (v3_q) begin
            dout_d = OUT_WD'(prod_q >>> FRAC_WD);
        end
    end

    always_ff @(posedge clk) begin : lut_ram
        if (lut_we && !start) begin
            lut_mem[lut_addr] <= lut_wdata;
        end
        if (acc) begin
            f1_q <= lut_mem[cnt_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prev_q   <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            x1_q     <= '0;
            xp1_q    <= '0;
            apo1_q   <= '0;
            apo2_q   <= '0;
            interp_q <= '0;
            prod_q   <= '0;
            dout_q   <= '0;
            dvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            x1_q     <= x1_d;
            xp1_q    <= xp1_d;
            apo1_q   <= apo1_d;
            apo2_q   <= apo2_d;
            interp_q <= interp_d;
            prod_q   <= prod_d;
            dout_q   <= dout_d;
            dvld_q   <= dvld_d;
        end
    end

    assign dbf_dout       = dout_q;
    assign dbf_dout_valid = dvld_q;

endmodule

// File: tb/tb_dbf_fine_apod_ch.sv
// Bench for dbf_fine_apod_ch: a default-size channel and a 4-entry-LUT channel share
// one stimulus stream and are checked every cycle against a sample-level model.
module tb_dbf_fine_apod_ch;

    localparam int DEPTH_B = 4096;
    localparam int DEPTH_S = 4;

    logic        clk = 1'b0;
    logic        rst_n, tx_en, start, fine_din_valid, lut_we;
    logic [13:0] fine_din;
    logic [11:0] lut_addr;
    logic [3:0]  lut_wdata;
    logic [15:0] apo_din;
    logic [31:0] dout_b, dout_s;
    logic        vld_b, vld_s;

    always #5 clk = ~clk;

    dbf_fine_apod_ch u_big (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start),
        .fine_din(fine_din), .fine_din_valid(fine_din_valid),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
        .apo_din(apo_din), .dbf_dout(dout_b), .dbf_dout_valid(vld_b)
    );

    dbf_fine_apod_ch #(.ADDR_WD(2)) u_small (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start),
        .fine_din(fine_din), .fine_din_valid(fine_din_valid),
        .lut_we(lut_we), .lut_addr(lut_addr[1:0]), .lut_wdata(lut_wdata),
        .apo_din(apo_din), .dbf_dout(dout_s), .dbf_dout_valid(vld_s)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int     due;
        longint y0;
        longint y1;
    } pend_t;

    int          lut_m [2][4096];
    int          cnt_m [2];
    int          prev_x;
    bit          first;
    int          cyc;
    pend_t       pq[$];
    bit          exp_v;
    logic [31:0] exp_d [2];

    function automatic void model_clear();
        pq.delete();
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        prev_x   = 0;
        first    = 1'b1;
        exp_v    = 1'b0;
        exp_d[0] = '0;
        exp_d[1] = '0;
    endfunction

    // Evaluate one clock edge from the inputs currently applied; results are due 3 edges later.
    function automatic void model_edge();
        int     x, a, xn1, f;
        longint y [2];
        pend_t  p;
        if (!rst_n) begin
            model_clear();
        end else begin
            if (lut_we && !start) begin
                lut_m[0][lut_addr]     = int'(lut_wdata);
                lut_m[1][lut_addr % 4] = int'(lut_wdata);
            end
            if (!start) begin
                model_clear();
            end else begin
                if (!tx_en && fine_din_valid) begin
                    x   = $signed(fine_din);
                    a   = $signed(apo_din);
                    xn1 = first ? 0 : prev_x;
                    for (int m = 0; m < 2; m++) begin
                        f    = lut_m[m][cnt_m[m]];
                        y[m] = ((longint'(x) * (16 - f) + longint'(xn1) * f) * a) >>> 4;
                    end
                    p.due = cyc + 3;
                    p.y0  = y[0];
                    p.y1  = y[1];
                    pq.push_back(p);
                    prev_x = x;
                    first  = 1'b0;
                    if (cnt_m[0] < DEPTH_B - 1) cnt_m[0]++;
                    if (cnt_m[1] < DEPTH_S - 1) cnt_m[1]++;
                end
                exp_v = 1'b0;
                if (pq.size() > 0 && pq[0].due == cyc) begin
                    p        = pq.pop_front();
                    exp_v    = 1'b1;
                    exp_d[0] = p.y0[31:0];
                    exp_d[1] = p.y1[31:0];
                end
            end
        end
        cyc++;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("big_valid", 32'(vld_b), 32'(exp_v));
        check("big_dout", dout_b, exp_d[0]);
        check("small_valid", 32'(vld_s), 32'(exp_v));
        check("small_dout", dout_s, exp_d[1]);
    endtask

    task automatic flush(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int x, input int a);
        fine_din       = x[13:0];
        apo_din        = a[15:0];
        fine_din_valid = 1'b1;
        step();
        fine_din_valid = 1'b0;
    endtask

    task automatic wlut(input int addr, input int d);
        lut_addr  = addr[11:0];
        lut_wdata = d[3:0];
        lut_we    = 1'b1;
        step();
        lut_we    = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int expv);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (vld_b !== 1'b1 && n < 6);
        check({tag, "_latency"}, n, 3);
        check(tag, dout_b, expv);
    endtask

    function automatic int rx();
        return int'($urandom_range(16383)) - 8192;
    endfunction

    function automatic int ra();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; tx_en = 1'b0; fine_din_valid = 1'b0;
        lut_we = 1'b0; fine_din = '0; lut_addr = '0; lut_wdata = '0; apo_din = '0;
        cyc = 0;
        model_clear();
        flush(2);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 4096; i++) wlut(i, (i < 4) ? 0 : int'($urandom_range(15)));

        // Pass-through with zero fraction, one at a time then back-to-back.
        start = 1'b1;
        step();
        send(100, 1);   expect_out("t2_100", 100);
        send(-200, 1);  expect_out("t2_m200", -200);
        send(8191, 1);  expect_out("t2_8191", 8191);
        send(-8192, 1); expect_out("t2_m8192", -8192);
        send(rx(), 1); send(rx(), 1); send(rx(), ra()); send(rx(), ra());
        flush(4);
        start = 1'b0;
        step();

        // Interpolation.
        wlut(0, 0); wlut(1, 8); wlut(2, 15);
        start = 1'b1;
        send(100, 1);  expect_out("t3_a", 100);
        send(300, 1);  expect_out("t3_b", 200);
        send(1000, 1); expect_out("t3_c", 343);
        start = 1'b0;
        step();

        // Apodization extremes.
        wlut(0, 0); wlut(1, 0);
        start = 1'b1;
        send(-8192, -32768); expect_out("t4_neg", 268435456);
        send(8191, 32767);   expect_out("t4_pos", 268394497);
        start = 1'b0;
        step();

        // Random fractions with valid gaps and tx_en gating.
        for (int i = 0; i < 64; i++) wlut(i, int'($urandom_range(15)));
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tx_en          = ($urandom_range(4) == 0);
            fine_din_valid = ($urandom_range(2) != 0);
            t = rx(); fine_din = t[13:0];
            t = ra(); apo_din  = t[15:0];
            step();
        end
        tx_en = 1'b0;
        fine_din_valid = 1'b0;

        // Asynchronous reset with samples in flight.
        send(rx(), ra());
        send(rx(), ra());
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_big_valid", 32'(vld_b), 0);
        check("rst_async_big_dout", dout_b, 0);
        check("rst_async_small_valid", 32'(vld_s), 0);
        check("rst_async_small_dout", dout_s, 0);
        model_clear();
        flush(2);
        #2 rst_n = 1'b1;
        send(500, 1);
        send(rx(), ra());
        flush(4);

        // Start drop mid-pipeline, with a sample on the falling cycle.
        send(rx(), ra());
        send(rx(), ra());
        start = 1'b0;
        fine_din_valid = 1'b1;
        step();
        fine_din_valid = 1'b0;
        flush(5);

        // Default-size counter saturation.
        start = 1'b1;
        fine_din_valid = 1'b1;
        for (int i = 0; i < 4100; i++) begin
            t = rx(); fine_din = t[13:0];
            t = ra(); apo_din  = t[15:0];
            step();
        end
        fine_din_valid = 1'b0;
        flush(4);
        start = 1'b0;
        step();

        // Small-LUT saturation; writes on start rise and during a line are ignored.
        wlut(0, 0); wlut(1, 4); wlut(2, 8); wlut(3, 12);
        start = 1'b1;
        lut_we = 1'b1; lut_addr = 12'd3; lut_wdata = 4'd1;
        step();
        lut_addr = 12'd2; lut_wdata = 4'd5;
        step();
        lut_we = 1'b0;
        for (int i = 0; i < 6; i++) send(rx(), ra());
        flush(4);
        start = 1'b0;
        step();
        start = 1'b1;
        for (int i = 0; i < 6; i++) send(rx(), ra());
        flush(4);
        start = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
